winograd_tile_gen: RTL

WINOGRAD_TILE_GEN -- requirements
Module: winograd_tile_gen

---
 rtl/wino_pkg.sv | 18 +
 rtl/wino_line_buf.sv | 38 +++
 rtl/winograd_tile_gen.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/wino_pkg.sv
// Shared constants, tile-count helper and FSM state type for the Winograd tile generator.
package wino_pkg;

  localparam int unsigned DEF_W  = 8;
  localparam int unsigned TILE   = 4;
  localparam int unsigned STRIDE = 2;

  // Tiles along one dimension for F(2x2,3x3) with no padding.
  function automatic int unsigned ntiles(input int unsigned dim);
    return (dim - 2) / 2;
  endfunction

  typedef enum logic [0:0] {
    StFill,
    StEmit
  } state_e;

endpackage

// File: rtl/wino_line_buf.sv
// Four-row circular line buffer: one pixel write port, one 4x4 column-window read port.
module wino_line_buf
  import wino_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned IMG_W = 8,
  localparam int unsigned CW   = $clog2(IMG_W)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [1:0]             wr_slot,
  input  logic [CW-1:0]          wr_col,
  input  logic [W-1:0]           wr_pix,
  input  logic [1:0]             rd_slot,
  input  logic [CW-1:0]          rd_col,
  output logic [TILE*TILE*W-1:0] rd_win
);

  logic [W-1:0] mem [4][IMG_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_slot][wr_col] <= wr_pix;
    end
  end

  // rd_slot is the oldest row; rows are packed oldest-first, (0,0) in the MSBs.
  always_comb begin
    rd_win = '0;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        rd_win[W*(TILE*TILE-1-(TILE*r+c)) +: W] =
          mem[2'(rd_slot + 2'(r))][CW'(32'(rd_col) + 32'(c))];
      end
    end
  end

endmodule

// File: rtl/winograd_tile_gen.sv
// Streams raster pixels into a line buffer and emits overlapping 4x4 stride-2 tiles.
// Optional tile_y/tile_x index outputs are enabled by defining WINO_TILE_IDX_EN.
module winograd_tile_gen
  import wino_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           in_pix,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [TILE*TILE*W-1:0] data,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   data_last
`ifdef WINO_TILE_IDX_EN
  ,
  output logic [5:0]             tile_y,
  output logic [5:0]             tile_x
`endif
);

  localparam int unsigned CW      = $clog2(IMG_W);
  localparam int unsigned NTX     = ntiles(IMG_W);
  localparam logic [5:0]  TxLast  = 6'(NTX - 1);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [6:0]  RowEnd  = 7'(IMG_H);

  state_e                 state_q;
  logic [6:0]             row_q;
  logic [CW-1:0]          col_q;
  logic [1:0]             slot_q;
  logic [5:0]             tx_q;
  logic                   valid_q;
  logic                   last_q;
  logic [TILE*TILE*W-1:0] data_q;

  logic                   accept, row_done, hs, tx_last, frame_end, load;
  logic [5:0]             load_tx;
  logic [CW-1:0]          rd_col;
  logic [TILE*TILE*W-1:0] win;

  assign in_ready  = (state_q == StFill) && !rst;
  assign accept    = in_valid && in_ready;
  assign row_done  = accept && (col_q == ColLast);
  assign hs        = valid_q && data_ready;
  assign tx_last   = (tx_q == TxLast);
  assign frame_end = (row_q == RowEnd);
  // Load the first tile on entry, then the next tile on every non-final handshake.
  assign load      = (state_q == StEmit) && (!valid_q || (hs && !tx_last));
  assign load_tx   = valid_q ? tx_q + 6'd1 : tx_q;
  assign rd_col    = CW'(32'(load_tx) * STRIDE);

  wino_line_buf #(
    .W     (W),
    .IMG_W (IMG_W)
  ) u_line_buf (
    .clk     (clk),
    .we      (accept),
    .wr_slot (slot_q),
    .wr_col  (col_q),
    .wr_pix  (in_pix),
    .rd_slot (slot_q),
    .rd_col  (rd_col),
    .rd_win  (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      row_q   <= '0;
      col_q   <= '0;
      slot_q  <= '0;
      tx_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (row_done) begin
              col_q  <= '0;
              slot_q <= slot_q + 2'd1;
              row_q  <= row_q + 7'd1;
              if (row_q[0] && (row_q >= 7'd3)) begin
                state_q <= StEmit;
                tx_q    <= '0;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StEmit: begin
          if (load) begin
            valid_q <= 1'b1;
            data_q  <= win;
            last_q  <= frame_end && (load_tx == TxLast);
            tx_q    <= load_tx;
          end else if (hs) begin
            // Last tile of the row accepted: slot_q already skips the two oldest rows.
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= StFill;
            if (frame_end) begin
              row_q  <= '0;
              slot_q <= '0;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign data_last  = last_q;

`ifdef WINO_TILE_IDX_EN
  logic [5:0] tile_y_q, tile_x_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_y_q <= '0;
      tile_x_q <= '0;
    end else if (load) begin
      tile_y_q <= 6'((row_q - 7'd4) >> 1);
      tile_x_q <= load_tx;
    end
  end

  assign tile_y = tile_y_q;
  assign tile_x = tile_x_q;
`endif

endmodule
